// File: rtl/onchip_mem_master_pkg.sv
// rtl/onchip_mem_master_pkg.sv - shared types and sizing for the on-chip memory initiator
package onchip_mem_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int RSP_FIFO_DEPTH = 4;

  // Wide enough to hold 0..RSP_FIFO_DEPTH for both the in-flight count and the FIFO fill level.
  localparam int CREDIT_W = $clog2(RSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/onchip_mem_master_rsp_fifo.sv
// rtl/onchip_mem_master_rsp_fifo.sv - show-ahead read-response FIFO with fill count
module rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop of an empty FIFO is ignored; a push into a full FIFO is only legal alongside a pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer and fill-level bookkeeping; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Control state flushes on reset so no stale words are presented afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

`ifndef SYNTHESIS
  // The issuer's credit accounting must never let a response arrive with nowhere to go.
  assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop_ok));
`endif

endmodule

// File: rtl/onchip_mem_master.sv
// rtl/onchip_mem_master.sv - Avalon-MM burst initiator for the on-chip payload memory
module onchip_mem_master
  import onchip_mem_master_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [CREDIT_W-1:0]     outstanding_q, outstanding_d;
  logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;

  logic [CREDIT_W-1:0]     fifo_count;
  logic                    fifo_empty;
  logic [CREDIT_W:0]       credit;
  logic                    issue;
  logic                    wr_fire;
  logic                    access;
  logic                    rsp_push;
  logic                    rsp_pop;

  // Every read in flight or already buffered holds one FIFO slot; issue only while a slot is free.
  assign credit   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign issue    = (state_q == ST_READ) && (credit < (CREDIT_W + 1)'(RSP_FIFO_DEPTH));
  assign wr_fire  = (state_q == ST_WRITE) && wr_valid;
  assign access   = wr_fire || issue;
  assign rsp_push = vld_sr_q[READ_LATENCY-1];
  assign rsp_pop  = rd_valid && rd_ready;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign wr_ready  = (state_q == ST_WRITE);
  assign rd_valid  = !fifo_empty;
  assign m_clken   = 1'b1;

  // Command sequencing: latch on accept, walk the burst, wait for the last read word, pulse done.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else if (cmd_write) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-return tracking: the shift register marks the cycle readdata is valid for each issue.
  always_comb begin
    vld_sr_d      = READ_LATENCY'({vld_sr_q, issue});
    outstanding_d = outstanding_q + CREDIT_W'(issue) - CREDIT_W'(rsp_push);
  end

  // Bus strobes are driven straight from state and registers; idle cycles present all zeros.
  always_comb begin
    m_chipselect = access;
    m_write      = wr_fire;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    if (access) begin
      m_address    = addr_q;
      m_byteenable = '1;
    end
    if (wr_fire) begin
      m_writedata = wr_data;
    end
  end

  // State and burst registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      vld_sr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      vld_sr_q      <= vld_sr_d;
    end
  end

  rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_push),
    .push_data (m_readdata),
    .pop       (rsp_pop),
    .pop_data  (rd_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/onchip_mem_master.md
# onchip_mem_master

Avalon-MM initiator that moves message payloads into and out of the dual-port on-chip memory in the receive-side accelerator. It attaches to the memory's second slave port (s2). It executes one command at a time: a burst of N 32-bit word writes fed from a valid/ready stream, or a burst of N word reads delivered to a valid/ready stream. Matching-engine logic uses it to deposit matched payloads and fetch buffered ones without Nios II involvement.

## Interface
- ADDR_W, 18, word address width of the memory port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- LEN_W, 16, command length width in words
- READ_LATENCY, 1, cycles from read issue edge to valid readdata (memory q is unregistered)
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  LEN_W  word count; 0 = no-op
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_W  write-payload stream
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  read-payload stream
- busy  out  1  command in progress (not IDLE)
- done  out  1  one-cycle completion pulse
- m_address  out  ADDR_W  memory address
- m_chipselect, m_write  out  1, 1  access strobe and direction
- m_byteenable  out  DATA_W/8  constant all-ones during an access, 0 otherwise
- m_writedata  out  DATA_W  write data
- m_clken  out  1  tied to 1
- m_readdata  in  DATA_W  memory read data

## Operation
- The FSM states are IDLE, WRITE, READ, DRAIN and DONE. cmd_ready = (state==IDLE).
- On command accept, cmd_addr is latched into addr and cmd_len into remaining. The FSM moves to WRITE or READ, or to DONE if cmd_len==0.
- WRITE:
  - wr_ready=1.
  - On each wr_valid cycle: m_chipselect=m_write=1, m_address=addr, m_writedata=wr_data. Then addr+1 and remaining-1.
  - On the handshake with remaining==1, go to DONE.
  - No bus access on gap cycles.
- READ:
  - Issue condition is credit = outstanding + fifo_count < 4.
  - On an issue: m_chipselect=1, m_write=0, m_address=addr. Then addr+1 and remaining-1.
  - Each issue sets a READ_LATENCY-deep valid shift register. Its output pushes m_readdata into a 4-entry response FIFO.
  - After the last issue, go to DRAIN.
- DRAIN: when outstanding==0 (last word is in the FIFO), go to DONE.
- DONE: done=1 for one cycle, then IDLE. rd_stream data may remain in the FIFO after done and drains under rd_ready.
- rd_valid = FIFO not empty, rd_data = FIFO head (show-ahead). Pop on rd_valid&rd_ready.
- Address arithmetic is modulo 2^ADDR_W: 0x3FFFF+1 → 0x00000.
- Simultaneous FIFO push and pop leaves the count unchanged. The credit rule guarantees no overflow; overflow is unreachable and checked by assertion.
- Bus outputs are combinational from state and registers. An access is sampled by the memory at the clk edge ending the cycle.

## Timing
- All registered outputs and state reset asynchronously to zero/IDLE on reset_n low.
  - done=0, busy=0, rd_valid=0.
  - m_chipselect=0, m_write=0, m_byteenable=0, m_address=0.
  - cmd_ready=1 while reset_n is high and in IDLE.
  - FIFO and shift register are flushed.
- Reset mid-command aborts it with no further bus accesses. The partial burst is not completed.
- First bus access occurs in the cycle after command accept.
- Write throughput is 1 word/cycle with wr_valid held high.
- Read throughput is 1 word/cycle with rd_ready high.
- With READ_LATENCY=1, rd_valid is first asserted 2 cycles after the first issue cycle.
- done asserts 1 cycle after entering DONE's preceding transition:
  - write: the cycle after the last write access;
  - read: the cycle after the last word enters the FIFO;
  - len 0: 1 cycle after accept.
- A new command is accepted no earlier than the cycle after done.

## Structure
- Package onchip_mem_master_pkg holds the state enum, RSP_FIFO_DEPTH=4, and the credit-counter width.
- Sub-module rsp_fifo is a synchronous show-ahead FIFO (depth 4, width DATA_W) with count output, instantiated once.

## Test plan
- Write cmd addr 0x00010, len 4, words A0..A3 back-to-back → chipselect&write on 4 consecutive cycles, addresses 0x10..0x13, byteenable 0xF, done the cycle after the last.
- Read same range with rd_ready=1 → rd_data A0..A3 in order, first rd_valid 2 cycles after first issue, done once A3 is in the FIFO.
- Read addr 0, len 8, rd_ready=0 → exactly 4 issues, then chipselect stays 0. Raising rd_ready → remaining 4 issued, 8 words in order, no loss or duplication.
- Write addr 0x3FFFF, len 3 → addresses 0x3FFFF, 0x00000, 0x00001. Insert a wr_valid gap → no access in the gap cycle.
- cmd_len=0 (either direction) → no chipselect, done pulse 1 cycle after accept, cmd_ready back the next cycle.
- Assert reset_n low mid-read with 2 words outstanding → chipselect, rd_valid, busy, done drop immediately, FIFO empty. After release, cmd_ready=1 and a fresh read returns correct data.
